// File: rtl/pipeline_ctrl.sv
// Hazard/stall controller: drives pipeline register write-enables and clears, sequences start-up,
// times out stuck data accesses and keeps saturating stall/flush counters.
module pipeline_ctrl #(
    parameter int INIT_CYCLES = 2,
    parameter int TIMEOUT     = 64
) (
    input  logic        clock,
    input  logic        rst,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rt,
    input  logic        ex_memRead,
    input  logic [4:0]  ex_rd,
    input  logic        mem_pcSrc,
    input  logic        dmem_req,
    input  logic        dmem_ready,
    input  logic        imem_ready,
    output logic        pc_we,
    output logic        if_id_we,
    output logic        id_ex_we,
    output logic        ex_mem_we,
    output logic        if_id_clear,
    output logic        id_ex_clear,
    output logic        ex_mem_clear,
    output logic        mem_wb_clear,
    output logic        timeout_err,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
);

    localparam logic [1:0] ST_INIT   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_DSTALL = 2'd2;

    localparam int         TW        = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT);
    localparam logic [3:0] INIT_LAST = 4'(INIT_CYCLES - 1);

    logic [1:0]    state, state_nxt;
    logic [3:0]    init_cnt;
    logic [TW-1:0] to_cnt, to_nxt;
    logic          load_use;
    logic          stall_now;
    logic          flush_hit;

    assign load_use  = ex_memRead && (ex_rd != 5'd0) &&
                       ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));
    assign stall_now = ((state == ST_RUN) && dmem_req && !dmem_ready) ||
                       ((state == ST_DSTALL) && !dmem_ready);

    always_comb begin
        pc_we        = 1'b1;
        if_id_we     = 1'b1;
        id_ex_we     = 1'b1;
        ex_mem_we    = 1'b1;
        if_id_clear  = 1'b0;
        id_ex_clear  = 1'b0;
        ex_mem_clear = 1'b0;
        mem_wb_clear = 1'b0;
        flush_hit    = 1'b0;
        state_nxt    = state;
        if (state == ST_INIT) begin
            pc_we        = 1'b0;
            if_id_we     = 1'b0;
            id_ex_we     = 1'b0;
            ex_mem_we    = 1'b0;
            if_id_clear  = 1'b1;
            id_ex_clear  = 1'b1;
            ex_mem_clear = 1'b1;
            mem_wb_clear = 1'b1;
            if (init_cnt == INIT_LAST)
                state_nxt = ST_RUN;
        end else if (stall_now) begin
            // Whole front end frozen; only the bubble into MEM/WB moves.
            pc_we        = 1'b0;
            if_id_we     = 1'b0;
            id_ex_we     = 1'b0;
            ex_mem_we    = 1'b0;
            mem_wb_clear = 1'b1;
            state_nxt    = ST_DSTALL;
        end else begin
            state_nxt = ST_RUN;
            if (mem_pcSrc) begin
                if_id_clear  = 1'b1;
                id_ex_clear  = 1'b1;
                ex_mem_clear = 1'b1;
                flush_hit    = 1'b1;
            end else if (load_use) begin
                pc_we       = 1'b0;
                if_id_we    = 1'b0;
                id_ex_clear = 1'b1;
            end else if (!imem_ready) begin
                pc_we       = 1'b0;
                if_id_clear = 1'b1;
            end
        end
    end

    // First stalled cycle (detected in RUN) counts as 1; counter saturates at TIMEOUT.
    always_comb begin
        to_nxt = {{(TW-1){1'b0}}, 1'b1};
        if (state == ST_DSTALL)
            to_nxt = (to_cnt == TO_MAX) ? to_cnt : to_cnt + 1'b1;
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state       <= ST_INIT;
            init_cnt    <= 4'd0;
            to_cnt      <= '0;
            timeout_err <= 1'b0;
            stall_cnt   <= 16'd0;
            flush_cnt   <= 16'd0;
        end else begin
            state <= state_nxt;
            if (state == ST_INIT)
                init_cnt <= init_cnt + 4'd1;
            if (stall_now) begin
                to_cnt <= to_nxt;
                if (to_nxt >= TO_MAX)
                    timeout_err <= 1'b1;
            end
            if ((state != ST_INIT) && !pc_we && (stall_cnt != 16'hFFFF))
                stall_cnt <= stall_cnt + 16'd1;
            if (flush_hit && (flush_cnt != 16'hFFFF))
                flush_cnt <= flush_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Randomized + directed bench for pipeline_ctrl; a hazard-class reference model feeds a scoreboard
// queue that a negedge monitor drains and compares every cycle.
module tb_pipeline_ctrl;

    localparam int INIT_CYCLES = 2;
    localparam int TIMEOUT     = 8;

    logic        clock = 1'b0;
    logic        rst;
    logic [4:0]  id_rs, id_rt, ex_rd;
    logic        id_uses_rt, ex_memRead, mem_pcSrc, dmem_req, dmem_ready, imem_ready;
    logic        pc_we, if_id_we, id_ex_we, ex_mem_we;
    logic        if_id_clear, id_ex_clear, ex_mem_clear, mem_wb_clear;
    logic        timeout_err;
    logic [15:0] stall_cnt, flush_cnt;

    pipeline_ctrl #(.INIT_CYCLES(INIT_CYCLES), .TIMEOUT(TIMEOUT)) dut (
        .clock(clock), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_memRead(ex_memRead), .ex_rd(ex_rd), .mem_pcSrc(mem_pcSrc), .dmem_req(dmem_req),
        .dmem_ready(dmem_ready), .imem_ready(imem_ready), .pc_we(pc_we), .if_id_we(if_id_we),
        .id_ex_we(id_ex_we), .ex_mem_we(ex_mem_we), .if_id_clear(if_id_clear),
        .id_ex_clear(id_ex_clear), .ex_mem_clear(ex_mem_clear), .mem_wb_clear(mem_wb_clear),
        .timeout_err(timeout_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [7:0]  ctl;   // {pc,if_id,id_ex,ex_mem}_we, {if_id,id_ex,ex_mem,mem_wb}_clear
        logic        err;
        logic [15:0] sc;
        logic [15:0] fc;
    } exp_t;

    typedef enum int { C_INIT, C_DSTALL, C_FLUSH, C_LOADUSE, C_ISTALL, C_NONE } cls_t;

    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;

    // Reference model state
    bit model_ok  = 0;
    int since_rst = 0;
    bit in_dstall = 0;
    int stall_run = 0;
    bit m_err     = 0;
    int m_sc      = 0;
    int m_fc      = 0;

    function automatic logic [7:0] ctl_of(cls_t c);
        case (c)
            C_INIT:    return 8'b0000_1111;
            C_DSTALL:  return 8'b0000_0001;
            C_FLUSH:   return 8'b1111_1110;
            C_LOADUSE: return 8'b0011_0100;
            C_ISTALL:  return 8'b0111_1000;
            default:   return 8'b1111_0000;
        endcase
    endfunction

    task automatic cycle(input bit r, input logic [4:0] rs, input logic [4:0] rt, input bit urt,
                         input bit mr, input logic [4:0] rd, input bit pcs, input bit dreq,
                         input bit drdy, input bit irdy);
        cls_t c;
        exp_t e;
        rst = r; id_rs = rs; id_rt = rt; id_uses_rt = urt; ex_memRead = mr; ex_rd = rd;
        mem_pcSrc = pcs; dmem_req = dreq; dmem_ready = drdy; imem_ready = irdy;
        if (since_rst < INIT_CYCLES)
            c = C_INIT;
        else if (in_dstall ? !drdy : (dreq && !drdy))
            c = C_DSTALL;
        else if (pcs)
            c = C_FLUSH;
        else if (mr && rd != 0 && (rd == rs || (urt && rd == rt)))
            c = C_LOADUSE;
        else if (!irdy)
            c = C_ISTALL;
        else
            c = C_NONE;
        if (model_ok && !r) begin
            e.ctl = ctl_of(c);
            e.err = m_err;
            e.sc  = 16'(m_sc);
            e.fc  = 16'(m_fc);
            sb.push_back(e);
        end
        @(posedge clock);
        if (r) begin
            model_ok = 1; since_rst = 0; in_dstall = 0; stall_run = 0;
            m_err = 0; m_sc = 0; m_fc = 0;
        end else if (c == C_INIT) begin
            since_rst++;
        end else begin
            if (c == C_DSTALL) begin
                in_dstall = 1;
                stall_run++;
                if (stall_run >= TIMEOUT) m_err = 1;
            end else begin
                in_dstall = 0;
                stall_run = 0;
            end
            if (ctl_of(c) >> 7 == 0 && m_sc < 65535) m_sc++;
            if (c == C_FLUSH && m_fc < 65535) m_fc++;
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 5'd1, 5'd2, 1, 0, 5'd3, 0, 0, 1, 1);
    endtask

    initial begin : monitor
        exp_t e, got;
        forever begin
            @(negedge clock);
            if (sb.size() > 0) begin
                e   = sb.pop_front();
                got = '{ctl: {pc_we, if_id_we, id_ex_we, ex_mem_we,
                              if_id_clear, id_ex_clear, ex_mem_clear, mem_wb_clear},
                         err: timeout_err, sc: stall_cnt, fc: flush_cnt};
                n_total++;
                if (got === e) n_pass++;
                else $display("FAIL outputs @%0t: got ctl=%b err=%b stall=%0d flush=%0d, want ctl=%b err=%b stall=%0d flush=%0d",
                              $time, got.ctl, got.err, got.sc, got.fc, e.ctl, e.err, e.sc, e.fc);
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1);
    end

    initial begin : stimulus
        rst = 0; id_rs = 0; id_rt = 0; id_uses_rt = 0; ex_memRead = 0; ex_rd = 0;
        mem_pcSrc = 0; dmem_req = 0; dmem_ready = 1; imem_ready = 1;
        @(posedge clock); #1;

        // Reset and start-up
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        idle(4);
        // Load-use on rs, on rt, then ex_rd=0 (no hazard)
        cycle(0, 5'd8, 5'd0, 0, 1, 5'd8, 0, 0, 1, 1);
        cycle(0, 5'd8, 5'd0, 0, 0, 5'd0, 0, 0, 1, 1);
        cycle(0, 5'd4, 5'd9, 1, 1, 5'd9, 0, 0, 1, 1);
        cycle(0, 5'd4, 5'd9, 0, 1, 5'd9, 0, 0, 1, 1);
        cycle(0, 5'd0, 5'd0, 1, 1, 5'd0, 0, 0, 1, 1);
        // Flush together with istall and load-use
        cycle(0, 5'd8, 5'd0, 0, 1, 5'd8, 1, 0, 0, 0);
        cycle(0, 5'd1, 5'd2, 0, 0, 5'd3, 0, 0, 1, 0);
        idle(1);
        // Five-cycle data stall, then ready
        for (int i = 0; i < 5; i++) cycle(0, 5'd1, 5'd2, 0, 0, 5'd3, 0, 1, 0, 1);
        cycle(0, 5'd1, 5'd2, 0, 0, 5'd3, 0, 1, 1, 1);
        idle(2);
        // Ten-cycle stall crosses TIMEOUT, err sticks, reset mid-stall clears it
        for (int i = 0; i < 10; i++) cycle(0, 5'd1, 5'd2, 0, 0, 5'd3, 0, 1, 0, 1);
        cycle(0, 5'd1, 5'd2, 0, 0, 5'd3, 0, 1, 1, 1);
        idle(2);
        cycle(0, 5'd1, 5'd2, 0, 0, 5'd3, 0, 1, 0, 1);
        cycle(0, 5'd1, 5'd2, 0, 0, 5'd3, 0, 1, 0, 1);
        cycle(1, 5'd1, 5'd2, 0, 0, 5'd3, 0, 1, 0, 1);
        idle(4);
        // Randomized mix
        for (int i = 0; i < 3000; i++) begin
            logic [4:0] rs, rt, rd;
            rs = 5'($urandom_range(0, 3));
            rt = 5'($urandom_range(0, 3));
            rd = 5'($urandom_range(0, 3));
            cycle(($urandom % 300) == 0, rs, rt, 1'($urandom), ($urandom % 3) == 0, rd,
                  ($urandom % 8) == 0, ($urandom % 4) == 0, ($urandom % 5) < 3,
                  ($urandom % 6) != 0);
        end
        // Saturation of stall_cnt
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        idle(2);
        for (int i = 0; i < 70000; i++) cycle(0, 5'd8, 5'd0, 0, 1, 5'd8, 0, 0, 1, 1);
        idle(2);

        @(negedge clock); #1;
        n_total++;
        if (sb.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
